// File: rtl/npc_ras_unit.sv
// Next-PC unit: owns the F-stage PC and selects the next fetch address, with a circular return-address stack.
// Latency: every redirect reaches f_pc on the next clk edge; stall_req and ras_used are combinational.
// Backpressure: stall holds PC and RAS; stall_req asks the pipeline to freeze until a jr/jalr operand is ready.
module npc_ras_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int                RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       d_valid,
  input  logic [ADDR_W-1:0]          d_pc,
  input  logic [ADDR_W-1:0]          imm32,
  input  logic [25:0]                imm26,
  input  logic [2:0]                 jctrl,
  input  logic                       cmp_out,
  input  logic [ADDR_W-1:0]          rs_val,
  input  logic                       rs_ready,
  input  logic                       exc_req,
  input  logic                       eret,
  input  logic [ADDR_W-1:0]          epc,
  input  logic                       fix_valid,
  input  logic [ADDR_W-1:0]          fix_pc,
  output logic [ADDR_W-1:0]          f_pc,
  output logic                       ras_used,
  output logic                       stall_req,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Flow-select encodings; 110/111 fall through to the sequential/branch case.
  localparam logic [2:0] JC_J    = 3'b001;
  localparam logic [2:0] JC_JAL  = 3'b010;
  localparam logic [2:0] JC_JR   = 3'b011;
  localparam logic [2:0] JC_JALR = 3'b100;
  localparam logic [2:0] JC_RET  = 3'b101;

  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] LINK_STEP = ADDR_W'(8);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // Architectural state.
  logic [ADDR_W-1:0] f_pc_q;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q;
  logic [CNT_W-1:0]  cnt_q;

  // Decode-path intermediates.
  logic              redirect_hi;
  logic              decode_act;
  logic              decode_commit;
  logic              ras_nonempty;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] link_addr;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] dec_target;
  logic              dec_push;
  logic              dec_pop;
  logic              dec_need_stall;
  logic              dec_from_ras;
  logic [ADDR_W-1:0] next_pc;
  logic [PTR_W-1:0]  top_inc;
  logic [PTR_W-1:0]  top_dec;

  // Exception, eret and E-stage fix all pre-empt the D-stage decode, even under stall.
  assign redirect_hi  = exc_req | eret | fix_valid;
  assign decode_act   = ~reset & ~redirect_hi & d_valid;
  assign ras_nonempty = (cnt_q != '0);

  assign seq_pc     = f_pc_q + PC_STEP;
  assign branch_tgt = d_pc + PC_STEP + imm32;
  assign jump_tgt   = {d_pc[ADDR_W-1:28], imm26, 2'b00};
  assign link_addr  = d_pc + LINK_STEP;
  assign ras_top    = ras_mem[top_q];

  // Pointer arithmetic wraps naturally because the depth is a power of two.
  assign top_inc = top_q + PTR_ONE;
  assign top_dec = top_q - PTR_ONE;

  // Decode the flow select into a target plus RAS push/pop and stall intent.
  always_comb begin
    dec_target     = seq_pc;
    dec_push       = 1'b0;
    dec_pop        = 1'b0;
    dec_need_stall = 1'b0;
    dec_from_ras   = 1'b0;
    case (jctrl)
      JC_J: begin
        dec_target = jump_tgt;
      end
      JC_JAL: begin
        dec_target = jump_tgt;
        dec_push   = 1'b1;
      end
      JC_JR: begin
        if (rs_ready) begin
          dec_target = rs_val;
        end else begin
          dec_need_stall = 1'b1;
        end
      end
      JC_JALR: begin
        if (rs_ready) begin
          dec_target = rs_val;
          dec_push   = 1'b1;
        end else begin
          dec_need_stall = 1'b1;
        end
      end
      JC_RET: begin
        if (rs_ready) begin
          // Operand already resolved: use it, but keep the stack in step with the call depth.
          dec_target = rs_val;
          dec_pop    = ras_nonempty;
        end else if (ras_nonempty) begin
          // Speculate on the most recent link; E stage corrects via fix_valid if wrong.
          dec_target   = ras_top;
          dec_pop      = 1'b1;
          dec_from_ras = 1'b1;
        end else begin
          dec_need_stall = 1'b1;
        end
      end
      default: begin
        dec_target = cmp_out ? branch_tgt : seq_pc;
      end
    endcase
  end

  assign stall_req     = decode_act & dec_need_stall;
  assign ras_used      = decode_act & dec_from_ras;
  assign decode_commit = decode_act & ~stall & ~dec_need_stall;

  // Select the next fetch PC by redirect priority; reset is applied in the register itself.
  always_comb begin
    next_pc = dec_target;
    if (exc_req) begin
      next_pc = EXC_VEC;
    end else if (eret) begin
      next_pc = epc;
    end else if (fix_valid) begin
      next_pc = fix_pc;
    end else if (stall | dec_need_stall & d_valid) begin
      next_pc = f_pc_q;
    end else if (!d_valid) begin
      next_pc = seq_pc;
    end
  end

  // F-stage PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q <= RESET_PC;
    end else begin
      f_pc_q <= next_pc;
    end
  end

  // RAS pointer and occupancy; a push on a full stack silently replaces the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (decode_commit) begin
      if (dec_push) begin
        top_q <= top_inc;
        if (cnt_q != CNT_FULL) begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end else if (dec_pop) begin
        top_q <= top_dec;
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  // RAS storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    if (!reset && decode_commit && dec_push) begin
      ras_mem[top_inc] <= link_addr;
    end
  end

  assign f_pc      = f_pc_q;
  assign ras_count = cnt_q;

endmodule

// File: tb/tb_npc_ras_unit.sv
// Self-checking bench for npc_ras_unit: directed test-plan steps followed by randomized traffic.
// Expected values come from a queue-based RAS model and a flat next-PC priority model.
module tb_npc_ras_unit;

  localparam int          AW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;
  localparam logic [31:0] EVEC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, stall, d_valid, cmp_out, rs_ready, exc_req, eret, fix_valid;
  logic [31:0] d_pc, imm32, rs_val, epc, fix_pc;
  logic [25:0] imm26;
  logic [2:0]  jctrl;
  logic [31:0] f_pc;
  logic        ras_used, stall_req;
  logic [2:0]  ras_count;

  npc_ras_unit #(
    .ADDR_W(AW), .RESET_PC(RPC), .EXC_VEC(EVEC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .d_valid(d_valid), .d_pc(d_pc),
    .imm32(imm32), .imm26(imm26), .jctrl(jctrl), .cmp_out(cmp_out),
    .rs_val(rs_val), .rs_ready(rs_ready), .exc_req(exc_req), .eret(eret),
    .epc(epc), .fix_valid(fix_valid), .fix_pc(fix_pc), .f_pc(f_pc),
    .ras_used(ras_used), .stall_req(stall_req), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: fetch PC and a return stack holding at most DEPTH links, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_stack [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_push(input logic [31:0] v);
    m_stack.push_back(v);
    if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; d_valid = 1'b0; cmp_out = 1'b0; rs_ready = 1'b0;
    exc_req = 1'b0; eret = 1'b0; fix_valid = 1'b0;
    d_pc = '0; imm32 = '0; rs_val = '0; epc = '0; fix_pc = '0; imm26 = '0; jctrl = '0;
  endtask

  // One clock: check combinational outputs before the edge, advance the model, check state after it.
  task automatic cycle(input string tag);
    logic        hi, dec, exp_sr, exp_ru;
    logic [2:0]  jt;
    logic [31:0] nxt;
    #1;
    hi     = exc_req || eret || fix_valid;
    jt     = (jctrl > 3'd5) ? 3'd0 : jctrl;
    dec    = !reset && !hi && d_valid;
    exp_sr = dec && !rs_ready && (jt == 3'd3 || jt == 3'd4 || (jt == 3'd5 && m_stack.size() == 0));
    exp_ru = dec && !rs_ready && jt == 3'd5 && m_stack.size() != 0;
    chk({tag, ".stall_req"}, 32'(stall_req), 32'(exp_sr));
    chk({tag, ".ras_used"},  32'(ras_used),  32'(exp_ru));
    nxt = m_pc;
    if (reset) begin
      nxt = RPC;
      m_stack.delete();
    end else if (exc_req)   nxt = EVEC;
    else if (eret)          nxt = epc;
    else if (fix_valid)     nxt = fix_pc;
    else if (stall || exp_sr) nxt = m_pc;
    else if (!d_valid)      nxt = m_pc + 32'd4;
    else begin
      case (jt)
        3'd1: nxt = {d_pc[31:28], imm26, 2'b00};
        3'd2: begin nxt = {d_pc[31:28], imm26, 2'b00}; m_push(d_pc + 32'd8); end
        3'd3: nxt = rs_val;
        3'd4: begin nxt = rs_val; m_push(d_pc + 32'd8); end
        3'd5: begin
          if (rs_ready) begin
            nxt = rs_val;
            if (m_stack.size() != 0) void'(m_stack.pop_back());
          end else begin
            nxt = m_stack.pop_back();
          end
        end
        default: nxt = cmp_out ? d_pc + 32'd4 + imm32 : m_pc + 32'd4;
      endcase
    end
    m_pc = nxt;
    @(posedge clk);
    #1;
    chk({tag, ".f_pc"},      f_pc,             m_pc);
    chk({tag, ".ras_count"}, 32'(ras_count),   32'(m_stack.size()));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] links [5];
    m_pc = 'x;
    idle();
    reset = 1'b1;
    @(negedge clk);

    // Reset and free-running sequential fetch.
    cycle("reset");
    chk("plan.reset_pc", f_pc, 32'h0000_3000);
    chk("plan.reset_cnt", 32'(ras_count), 32'd0);
    reset = 1'b0;
    cycle("seq1");
    chk("plan.seq1", f_pc, 32'h0000_3004);
    cycle("seq2");
    chk("plan.seq2", f_pc, 32'h0000_3008);

    // Conditional branch taken and not taken.
    d_valid = 1'b1; d_pc = 32'h3010; jctrl = 3'b000; imm32 = 32'h20; cmp_out = 1'b1;
    cycle("br_taken");
    chk("plan.br_taken", f_pc, 32'h0000_3034);
    cmp_out = 1'b0;
    cycle("br_not");
    chk("plan.br_not", f_pc, 32'h0000_3038);

    // jal pushes, predicted ret pops, E-stage fix corrects.
    idle(); d_valid = 1'b1; jctrl = 3'b010; d_pc = 32'h3000; imm26 = 26'h000_1000;
    cycle("jal");
    chk("plan.jal_pc", f_pc, 32'h0000_4000);
    chk("plan.jal_cnt", 32'(ras_count), 32'd1);
    idle(); d_valid = 1'b1; jctrl = 3'b101; d_pc = 32'h4010;
    cycle("ret_pred");
    chk("plan.ret_pc", f_pc, 32'h0000_3008);
    chk("plan.ret_cnt", 32'(ras_count), 32'd0);
    idle(); fix_valid = 1'b1; fix_pc = 32'h5000;
    cycle("fix");
    chk("plan.fix_pc", f_pc, 32'h0000_5000);

    // Overflow: five calls into a four-deep stack keep the four newest links.
    for (int i = 0; i < 5; i++) begin
      idle(); d_valid = 1'b1; jctrl = 3'b010;
      d_pc = 32'h1000 * (i + 1); imm26 = 26'h100 + 26'(i);
      links[i] = d_pc + 32'd8;
      cycle("ovf_jal");
    end
    chk("plan.ovf_cnt", 32'(ras_count), 32'd4);
    for (int i = 4; i >= 1; i--) begin
      idle(); d_valid = 1'b1; jctrl = 3'b101; d_pc = 32'h7000;
      cycle("ovf_ret");
      chk("plan.ovf_ret_pc", f_pc, links[i]);
    end
    idle(); d_valid = 1'b1; jctrl = 3'b101; d_pc = 32'h7000;
    cycle("ovf_empty");
    chk("plan.ovf_hold", f_pc, links[1]);

    // Priority: exception beats eret and stall, eret beats stall.
    idle(); stall = 1'b1; exc_req = 1'b1; eret = 1'b1; epc = 32'h3100;
    d_valid = 1'b1; jctrl = 3'b010; d_pc = 32'h2000;
    cycle("prio_exc");
    chk("plan.prio_exc", f_pc, 32'h0000_4180);
    exc_req = 1'b0;
    cycle("prio_eret");
    chk("plan.prio_eret", f_pc, 32'h0000_3100);

    // jr waits for its operand, then redirects.
    idle(); d_valid = 1'b1; jctrl = 3'b011; rs_ready = 1'b0; rs_val = 32'hdead_beef;
    cycle("jr_wait");
    chk("plan.jr_hold", f_pc, 32'h0000_3100);
    rs_ready = 1'b1; rs_val = 32'h3200;
    cycle("jr_go");
    chk("plan.jr_pc", f_pc, 32'h0000_3200);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      idle();
      reset     = ($urandom_range(0, 63) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      exc_req   = ($urandom_range(0, 31) == 0);
      eret      = ($urandom_range(0, 31) == 0);
      fix_valid = ($urandom_range(0, 31) == 0);
      d_valid   = ($urandom_range(0, 3) != 0);
      cmp_out   = $urandom_range(0, 1) == 1;
      rs_ready  = $urandom_range(0, 1) == 1;
      d_pc      = $urandom & 32'hffff_fffc;
      imm32     = $urandom & 32'hffff_fffc;
      imm26     = 26'($urandom);
      rs_val    = $urandom;
      epc       = $urandom;
      fix_pc    = $urandom;
      r = $urandom_range(0, 9);
      if (r < 2)      jctrl = 3'b000;
      else if (r < 5) jctrl = 3'b010;
      else if (r < 8) jctrl = 3'b101;
      else            jctrl = 3'($urandom_range(0, 7));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
